// File: rtl/cnoc_pkg.sv
// Shared definitions for the CNOC portal mux: header field layout, FSM state
// encodings and a constant-foldable clog2 helper.
package cnoc_pkg;

  localparam int HDR_CNT_LSB = 0;
  localparam int HDR_CNT_W   = 16;
  localparam int HDR_MTH_LSB = 16;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BODY = 1'b1
  } ser_state_e;

  typedef enum logic {
    R_HDR  = 1'b0,
    R_BODY = 1'b1
  } des_state_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/cnoc_msg_fifo.sv
// Output word FIFO for the serialized indication stream; head word is visible
// combinationally and fullness is judged before any same-cycle pop.
module cnoc_msg_fifo
  import cnoc_pkg::*;
#(
  parameter int WORD_W    = 32,
  parameter int OUT_DEPTH = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              enq_i,
  input  logic [WORD_W-1:0] enq_data_i,
  input  logic              deq_i,
  output logic [WORD_W-1:0] head_o,
  output logic              valid_o,
  output logic              full_o
);

  localparam int AW = clog2(OUT_DEPTH);

  logic [WORD_W-1:0] mem_q [OUT_DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW:0]       count_q, count_d;
  logic              do_enq, do_deq;

  assign full_o  = (count_q == (AW+1)'(OUT_DEPTH));
  assign valid_o = (count_q != '0);
  assign do_enq  = enq_i && !full_o;
  assign do_deq  = deq_i && valid_o;
  assign head_o  = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_enq) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_deq) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_enq, do_deq})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // NOTE: the storage array has no reset; validity is carried entirely by the count.
  always_ff @(posedge clk_i) begin
    if (do_enq) mem_q[wr_ptr_q] <= enq_data_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/cnoc_portal_mux.sv
// Portal mux: serializes indication channels into one word stream and routes an
// inbound word stream to request channels. Define CNOC_RR_ARB_EN for round-robin grant.
module cnoc_portal_mux
  import cnoc_pkg::*;
#(
  parameter int WORD_W    = 32,
  parameter int NUM_IND   = 2,
  parameter int NUM_REQ   = 3,
  parameter int OUT_DEPTH = 4
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [NUM_IND*WORD_W-1:0] ind_first,
  input  logic [NUM_IND-1:0]        ind_not_empty,
  input  logic [NUM_IND*16-1:0]     ind_size,
  output logic [NUM_IND-1:0]        ind_deq,
  output logic [WORD_W-1:0]         msg_out_data,
  output logic                      msg_out_valid,
  input  logic                      msg_out_deq,
  output logic                      intr,
  input  logic [WORD_W-1:0]         req_in_data,
  input  logic                      req_in_en,
  output logic                      req_in_rdy,
  output logic [WORD_W-1:0]         req_enq_v,
  output logic [NUM_REQ-1:0]        req_enq,
  input  logic [NUM_REQ-1:0]        req_rdy,
  output logic [15:0]               req_drop_cnt
);

  localparam int          IND_IW   = (NUM_IND > 1) ? clog2(NUM_IND) : 1;
  localparam int          REQ_IW   = (NUM_REQ > 1) ? clog2(NUM_REQ) : 1;
  localparam int          MTH_W    = WORD_W - HDR_MTH_LSB;
  localparam logic [15:0] WORD_W16 = 16'(WORD_W);

  // ---------------- indication serializer ----------------
  ser_state_e             ser_state_q, ser_state_d;
  logic [IND_IW-1:0]      ser_ch_q, ser_ch_d;
  logic [HDR_CNT_W-1:0]   ser_cnt_q, ser_cnt_d;
  logic                   grant_vld;
  logic [IND_IW-1:0]      grant_idx;
  logic [15:0]            grant_size, grant_nw;
  logic                   fifo_enq, fifo_full;
  logic [WORD_W-1:0]      fifo_wdata;

`ifdef CNOC_RR_ARB_EN
  logic [IND_IW-1:0] rr_ptr_q, rr_c;
  logic              hdr_grant;

  // Walk the search order backwards so the first requester after the pointer wins.
  always_comb begin
    grant_vld = |ind_not_empty;
    grant_idx = '0;
    rr_c      = '0;
    for (int k = NUM_IND - 1; k >= 0; k--) begin
      rr_c = IND_IW'((int'(rr_ptr_q) + 1 + k) % NUM_IND);
      if (ind_not_empty[rr_c]) grant_idx = rr_c;
    end
  end

  assign hdr_grant = fifo_enq && (ser_state_q == S_IDLE);

  always_ff @(posedge CLK) begin
    if (RST)            rr_ptr_q <= '0;
    else if (hdr_grant) rr_ptr_q <= grant_idx;
  end
`else
  always_comb begin
    grant_vld = |ind_not_empty;
    grant_idx = '0;
    for (int i = NUM_IND - 1; i >= 0; i--) begin
      if (ind_not_empty[i]) grant_idx = IND_IW'(i);
    end
  end
`endif

  assign grant_size = ind_size[grant_idx*16 +: 16];
  assign grant_nw   = (grant_size / WORD_W16) + {15'd0, |(grant_size % WORD_W16)};

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    ser_state_d = ser_state_q;
    ser_ch_d    = ser_ch_q;
    ser_cnt_d   = ser_cnt_q;
    fifo_enq    = 1'b0;
    fifo_wdata  = '0;
    ind_deq     = '0;
    if (!RST) begin
      case (ser_state_q)
        S_IDLE: begin
          if (!fifo_full && grant_vld) begin
            fifo_enq   = 1'b1;
            fifo_wdata = {MTH_W'(grant_idx), grant_nw + 16'd1};
            ser_ch_d   = grant_idx;
            ser_cnt_d  = grant_nw;
            if (grant_nw != '0) ser_state_d = S_BODY;
          end
        end
        S_BODY: begin
          if (!fifo_full && ind_not_empty[ser_ch_q]) begin
            fifo_enq          = 1'b1;
            fifo_wdata        = ind_first[ser_ch_q*WORD_W +: WORD_W];
            ind_deq[ser_ch_q] = 1'b1;
            ser_cnt_d         = ser_cnt_q - 16'd1;
            if (ser_cnt_q == 16'd1) ser_state_d = S_IDLE;
          end
        end
        default: ser_state_d = S_IDLE;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignment so all flops update from pre-edge values.
  always_ff @(posedge CLK) begin
    if (RST) begin
      ser_state_q <= S_IDLE;
      ser_ch_q    <= '0;
      ser_cnt_q   <= '0;
    end else begin
      ser_state_q <= ser_state_d;
      ser_ch_q    <= ser_ch_d;
      ser_cnt_q   <= ser_cnt_d;
    end
  end

  cnoc_msg_fifo #(
    .WORD_W   (WORD_W),
    .OUT_DEPTH(OUT_DEPTH)
  ) u_out_fifo (
    .clk_i     (CLK),
    .rst_i     (RST),
    .enq_i     (fifo_enq),
    .enq_data_i(fifo_wdata),
    .deq_i     (msg_out_deq),
    .head_o    (msg_out_data),
    .valid_o   (msg_out_valid),
    .full_o    (fifo_full)
  );

  assign intr = msg_out_valid;

  // ---------------- request deserializer ----------------
  des_state_e           des_state_q, des_state_d;
  logic [MTH_W-1:0]     des_mth_q, des_mth_d;
  logic [HDR_CNT_W-1:0] des_cnt_q, des_cnt_d;
  logic [15:0]          drop_q, drop_d;
  logic [HDR_CNT_W-1:0] in_cnt;
  logic [MTH_W-1:0]     in_mth;
  logic                 des_hit;
  logic [REQ_IW-1:0]    des_ch;

  assign in_cnt    = req_in_data[HDR_CNT_LSB +: HDR_CNT_W];
  assign in_mth    = req_in_data[HDR_MTH_LSB +: MTH_W];
  assign des_hit   = (des_mth_q < MTH_W'(NUM_REQ));
  assign des_ch    = des_mth_q[REQ_IW-1:0];
  assign req_enq_v = req_in_data;

  always_comb begin
    des_state_d = des_state_q;
    des_mth_d   = des_mth_q;
    des_cnt_d   = des_cnt_q;
    drop_d      = drop_q;
    req_in_rdy  = 1'b0;
    req_enq     = '0;
    case (des_state_q)
      R_HDR: begin
        req_in_rdy = 1'b1;
        if (req_in_en) begin
          des_mth_d = in_mth;
          // A zero count still means the header itself, so no body follows.
          des_cnt_d = (in_cnt == '0) ? '0 : in_cnt - 16'd1;
          if (in_cnt > 16'd1) des_state_d = R_BODY;
        end
      end
      R_BODY: begin
        req_in_rdy = des_hit ? req_rdy[des_ch] : 1'b1;
        if (req_in_en && req_in_rdy) begin
          if (des_hit)                 req_enq[des_ch] = 1'b1;
          else if (drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
          des_cnt_d = des_cnt_q - 16'd1;
          if (des_cnt_q == 16'd1) des_state_d = R_HDR;
        end
      end
      default: des_state_d = R_HDR;
    endcase
    if (RST) req_enq = '0;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      des_state_q <= R_HDR;
      des_mth_q   <= '0;
      des_cnt_q   <= '0;
      drop_q      <= '0;
    end else begin
      des_state_q <= des_state_d;
      des_mth_q   <= des_mth_d;
      des_cnt_q   <= des_cnt_d;
      drop_q      <= drop_d;
    end
  end

  assign req_drop_cnt = drop_q;

endmodule

// File: tb/tb_cnoc_portal_mux.sv
// Directed bench for cnoc_portal_mux at default parameters; arbitration
// expectations follow CNOC_RR_ARB_EN when it is defined.
module tb_cnoc_portal_mux;

  localparam int WORD_W    = 32;
  localparam int NUM_IND   = 2;
  localparam int NUM_REQ   = 3;
  localparam int OUT_DEPTH = 4;

  logic                      CLK = 1'b0;
  logic                      RST;
  logic [NUM_IND*WORD_W-1:0] ind_first;
  logic [NUM_IND-1:0]        ind_not_empty;
  logic [NUM_IND*16-1:0]     ind_size;
  logic [NUM_IND-1:0]        ind_deq;
  logic [WORD_W-1:0]         msg_out_data;
  logic                      msg_out_valid;
  logic                      msg_out_deq;
  logic                      intr;
  logic [WORD_W-1:0]         req_in_data;
  logic                      req_in_en;
  logic                      req_in_rdy;
  logic [WORD_W-1:0]         req_enq_v;
  logic [NUM_REQ-1:0]        req_enq;
  logic [NUM_REQ-1:0]        req_rdy;
  logic [15:0]               req_drop_cnt;

  cnoc_portal_mux #(
    .WORD_W   (WORD_W),
    .NUM_IND  (NUM_IND),
    .NUM_REQ  (NUM_REQ),
    .OUT_DEPTH(OUT_DEPTH)
  ) dut (
    .CLK          (CLK),
    .RST          (RST),
    .ind_first    (ind_first),
    .ind_not_empty(ind_not_empty),
    .ind_size     (ind_size),
    .ind_deq      (ind_deq),
    .msg_out_data (msg_out_data),
    .msg_out_valid(msg_out_valid),
    .msg_out_deq  (msg_out_deq),
    .intr         (intr),
    .req_in_data  (req_in_data),
    .req_in_en    (req_in_en),
    .req_in_rdy   (req_in_rdy),
    .req_enq_v    (req_enq_v),
    .req_enq      (req_enq),
    .req_rdy      (req_rdy),
    .req_drop_cnt (req_drop_cnt)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;
  int deq0_cnt = 0;
  int deq1_cnt = 0;

  always @(posedge CLK) begin
    if (ind_deq[0]) deq0_cnt <= deq0_cnt + 1;
    if (ind_deq[1]) deq1_cnt <= deq1_cnt + 1;
  end

  localparam logic [31:0] W_A = 32'hA0A0_0001;
  localparam logic [31:0] W_B = 32'hB0B0_0002;
  localparam logic [31:0] W_C0 = 32'hC000_00C0;
  localparam logic [31:0] W_C1 = 32'hC111_00C1;
  localparam logic [31:0] W_D = 32'hD00D_D00D;
  localparam logic [31:0] W_X = 32'h1234_5678;
  localparam logic [31:0] W_Y = 32'h9ABC_DEF0;
  localparam logic [31:0] W_Z = 32'h5A5A_A5A5;
  localparam logic [31:0] W_W = 32'h0BAD_F00D;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  logic [31:0] cap [8];
  logic [31:0] exp_arb [8];
  int n;
  int base0, base1;

  initial begin
    RST = 1'b1; ind_first = '0; ind_not_empty = '0; ind_size = '0;
    msg_out_deq = 1'b0; req_in_data = '0; req_in_en = 1'b0; req_rdy = '0;
    step(); step();
    check("rst_valid", {31'd0, msg_out_valid}, 32'd0);
    check("rst_intr", {31'd0, intr}, 32'd0);
    check("rst_drop", {16'd0, req_drop_cnt}, 32'd0);
    check("rst_ind_deq", {30'd0, ind_deq}, 32'd0);
    check("rst_req_enq", {29'd0, req_enq}, 32'd0);
    RST = 1'b0;
    #1 check("rst_req_in_rdy", {31'd0, req_in_rdy}, 32'd1);

    // Serialize ch1, 64 bits -> header + two body words
    base1 = deq1_cnt;
    ind_size = {16'd64, 16'd0};
    ind_first = {W_A, 32'd0};
    ind_not_empty = 2'b10;
    #1 check("s1_hdr_cycle_deq", {30'd0, ind_deq}, 32'd0);
    step();
    check("s1_body0_deq", {30'd0, ind_deq}, 32'd2);
    step();
    ind_first = {W_B, 32'd0};
    #1 check("s1_body1_deq", {30'd0, ind_deq}, 32'd2);
    step();
    ind_not_empty = 2'b00;
    #1 check("s1_done_deq", {30'd0, ind_deq}, 32'd0);
    check("s1_deq1_count", 32'(deq1_cnt - base1), 32'd2);
    check("s1_intr", {31'd0, intr}, 32'd1);
    msg_out_deq = 1'b1;
    check("s1_word0", msg_out_data, 32'h0001_0003);
    step();
    check("s1_word1", msg_out_data, W_A);
    step();
    check("s1_word2", msg_out_data, W_B);
    step();
    msg_out_deq = 1'b0;
    #1 check("s1_drained", {31'd0, msg_out_valid}, 32'd0);

    // Header-only message on ch0
    base0 = deq0_cnt;
    ind_size = {16'd0, 16'd0};
    ind_first = {32'd0, W_D};
    ind_not_empty = 2'b01;
    #1 check("s2_hdr_cycle_deq", {30'd0, ind_deq}, 32'd0);
    step();
    ind_not_empty = 2'b00;
    #1 check("s2_word", msg_out_data, 32'h0000_0001);
    check("s2_valid", {31'd0, msg_out_valid}, 32'd1);
    check("s2_no_deq", {30'd0, ind_deq}, 32'd0);
    msg_out_deq = 1'b1;
    step();
    msg_out_deq = 1'b0;
    #1 check("s2_drained", {31'd0, msg_out_valid}, 32'd0);
    check("s2_deq0_count", 32'(deq0_cnt - base0), 32'd0);

    // Arbitration with both channels always ready
    RST = 1'b1; step(); RST = 1'b0;
`ifdef CNOC_RR_ARB_EN
    exp_arb = '{32'h0001_0002, W_C1, 32'h0000_0002, W_C0,
                32'h0001_0002, W_C1, 32'h0000_0002, W_C0};
`else
    exp_arb = '{32'h0000_0002, W_C0, 32'h0000_0002, W_C0,
                32'h0000_0002, W_C0, 32'h0000_0002, W_C0};
`endif
    base1 = deq1_cnt;
    ind_size = {16'd32, 16'd32};
    ind_first = {W_C1, W_C0};
    ind_not_empty = 2'b11;
    msg_out_deq = 1'b1;
    n = 0;
    #1;
    for (int c = 0; c < 40 && n < 8; c++) begin
      if (msg_out_valid) begin
        cap[n] = msg_out_data;
        n++;
      end
      step();
    end
    check("s3_word_count", 32'(n), 32'd8);
    for (int i = 0; i < 8; i++) check($sformatf("s3_word%0d", i), cap[i], exp_arb[i]);
`ifndef CNOC_RR_ARB_EN
    check("s3_ch1_starved", 32'(deq1_cnt - base1), 32'd0);
`endif
    ind_not_empty = 2'b00;
    msg_out_deq = 1'b0;
    RST = 1'b1; step(); RST = 1'b0;

    // Deserialize to channel 2 with backpressure
    req_rdy = 3'b011;
    req_in_data = 32'h0002_0003;
    req_in_en = 1'b1;
    #1 check("s4_hdr_rdy", {31'd0, req_in_rdy}, 32'd1);
    check("s4_hdr_enq", {29'd0, req_enq}, 32'd0);
    step();
    req_in_data = W_X;
    for (int i = 0; i < 3; i++) begin
      #1 check($sformatf("s4_stall%0d_rdy", i), {31'd0, req_in_rdy}, 32'd0);
      check($sformatf("s4_stall%0d_enq", i), {29'd0, req_enq}, 32'd0);
      step();
    end
    req_rdy = 3'b111;
    #1 check("s4_x_enq", {29'd0, req_enq}, 32'd4);
    check("s4_x_data", req_enq_v, W_X);
    step();
    req_in_data = W_Y;
    #1 check("s4_y_enq", {29'd0, req_enq}, 32'd4);
    check("s4_y_data", req_enq_v, W_Y);
    step();
    req_in_en = 1'b0;
    #1 check("s4_back_hdr_rdy", {31'd0, req_in_rdy}, 32'd1);
    check("s4_back_hdr_enq", {29'd0, req_enq}, 32'd0);

    // Drop to a non-existent channel
    req_in_data = 32'h0007_0002;
    req_in_en = 1'b1;
    step();
    req_in_data = W_Z;
    #1 check("s5_drop_rdy", {31'd0, req_in_rdy}, 32'd1);
    check("s5_drop_enq", {29'd0, req_enq}, 32'd0);
    step();
    req_in_en = 1'b0;
    #1 check("s5_drop_cnt", {16'd0, req_drop_cnt}, 32'd1);

    // Zero count header acts as a header-only message
    req_in_data = 32'h0000_0000;
    req_in_en = 1'b1;
    step();
    req_in_data = 32'h0000_0002;
    #1 check("s5_zero_hdr_enq", {29'd0, req_enq}, 32'd0);
    step();
    req_in_data = W_W;
    #1 check("s5_zero_next_enq", {29'd0, req_enq}, 32'd1);
    step();
    req_in_en = 1'b0;

    // Output backpressure then reset mid-body
    base0 = deq0_cnt;
    ind_size = {16'd0, 16'd160};
    ind_first = {32'd0, W_D};
    ind_not_empty = 2'b01;
    msg_out_deq = 1'b0;
    repeat (8) step();
    check("s6_full_deq_count", 32'(deq0_cnt - base0), 32'd3);
    check("s6_full_stall", {30'd0, ind_deq}, 32'd0);
    check("s6_full_head", msg_out_data, 32'h0000_0006);
    msg_out_deq = 1'b1;
    #1 check("s6_pop_full_deq", {30'd0, ind_deq}, 32'd0);
    step();
    check("s6_pop_room_deq", {30'd0, ind_deq}, 32'd1);
    step();
    msg_out_deq = 1'b0;
    RST = 1'b1;
    #1 check("s6_rst_deq", {30'd0, ind_deq}, 32'd0);
    step();
    RST = 1'b0;
    #1 check("s6_post_valid", {31'd0, msg_out_valid}, 32'd0);
    check("s6_post_intr", {31'd0, intr}, 32'd0);
    check("s6_post_deq", {30'd0, ind_deq}, 32'd0);
    check("s6_post_drop", {16'd0, req_drop_cnt}, 32'd0);
    ind_not_empty = 2'b00;
    step();
    check("s6_post_deq_count", 32'(deq0_cnt - base0), 32'd4);
    check("s6_post_valid2", {31'd0, msg_out_valid}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
